// File: rtl/pipe_if_stage.sv
`timescale 1ns/1ps
// Instruction-fetch stage: PC, single-outstanding req/gnt/rvalid fetch, redirect with wrong-path kill,
// and an IF/ID slot held under stall. Define IF_PERF_CNT_EN to build the delivered/killed counters.
module pipe_if_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [31:0]     if_inst_o,
    output logic [XLEN-1:0] if_npc_o,
    output logic [31:0]     perf_fetch_o,
    output logic [31:0]     perf_kill_o
);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    localparam logic [XLEN-1:0] Step      = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] AlignMask = {{(XLEN-2){1'b1}}, 2'b00};

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            kill_q, kill_d;
    logic [31:0]     hold_inst_q, hold_inst_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] slot_pc_q, slot_pc_d;
    logic [31:0]     slot_inst_q, slot_inst_d;
    logic [XLEN-1:0] slot_npc_q, slot_npc_d;
    logic            slot_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StReq;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= '0;
            kill_q      <= 1'b0;
            hold_inst_q <= '0;
            valid_q     <= 1'b0;
            slot_pc_q   <= '0;
            slot_inst_q <= '0;
            slot_npc_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            kill_q      <= kill_d;
            hold_inst_q <= hold_inst_d;
            valid_q     <= valid_d;
            slot_pc_q   <= slot_pc_d;
            slot_inst_q <= slot_inst_d;
            slot_npc_q  <= slot_npc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        kill_d      = kill_q;
        hold_inst_d = hold_inst_q;
        valid_d     = valid_q;
        slot_pc_d   = slot_pc_q;
        slot_inst_d = slot_inst_q;
        slot_npc_d  = slot_npc_q;
        slot_free   = !valid_q || !stall_i;

        // A consumed slot empties unless refilled below.
        if (slot_free) valid_d = 1'b0;

        case (state_q)
            StReq: begin
                if (imem_gnt_i) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + Step;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else if (slot_free) begin
                        valid_d     = 1'b1;
                        slot_pc_d   = fetch_pc_q;
                        slot_inst_d = imem_rdata_i;
                        slot_npc_d  = fetch_pc_q + Step;
                        state_d     = StReq;
                    end else begin
                        hold_inst_d = imem_rdata_i;
                        state_d     = StHold;
                    end
                end
            end
            StHold: begin
                if (!stall_i) begin
                    valid_d     = 1'b1;
                    slot_pc_d   = fetch_pc_q;
                    slot_inst_d = hold_inst_q;
                    slot_npc_d  = fetch_pc_q + Step;
                    state_d     = StReq;
                end
            end
            default: state_d = StReq;
        endcase

        // Redirect overrides everything above; an in-flight request becomes wrong-path.
        if (redirect_i) begin
            pc_d    = redirect_pc_i & AlignMask;
            valid_d = 1'b0;
            case (state_q)
                StReq: begin
                    state_d = imem_gnt_i ? StWait : StReq;
                    kill_d  = imem_gnt_i;
                end
                StWait: begin
                    state_d = imem_rvalid_i ? StReq : StWait;
                    kill_d  = !imem_rvalid_i;
                end
                default: begin
                    state_d = StReq;
                    kill_d  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        imem_req_o  = (state_q == StReq);
        imem_addr_o = pc_q;
        if_valid_o  = valid_q;
        if_pc_o     = slot_pc_q;
        if_inst_o   = slot_inst_q;
        if_npc_o    = slot_npc_q;
    end

`ifdef IF_PERF_CNT_EN
    logic        resp_drop;
    logic [31:0] fetch_cnt_q;
    logic [31:0] kill_cnt_q;

    assign resp_drop = (state_q == StWait) && imem_rvalid_i && (kill_q || redirect_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (valid_q && !stall_i && !redirect_i) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (resp_drop) kill_cnt_q <= kill_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_o = fetch_cnt_q;
    assign perf_kill_o  = kill_cnt_q;
`else
    assign perf_fetch_o = 32'h0;
    assign perf_kill_o  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
`timescale 1ns/1ps
// Bench for pipe_if_stage: directed fetch, stall, redirect, wrap and reset scenarios checked every
// cycle against a transaction-level fetch model. Expected counters follow IF_PERF_CNT_EN.
module tb_pipe_if_stage;

`ifdef IF_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif
    localparam logic [31:0] RstPc = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o, if_inst_o, if_npc_o, perf_fetch_o, perf_kill_o;

    logic        w_stall, w_redir, w_req, w_gnt, w_rvalid, w_valid;
    logic [31:0] w_rpc, w_addr, w_rdata, w_pc, w_inst, w_npc, w_pf, w_pk;

    always #5 clk = ~clk;

    pipe_if_stage #(.XLEN(32), .RESET_PC(RstPc), .PC_STEP(4)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_npc_o(if_npc_o),
        .perf_fetch_o(perf_fetch_o), .perf_kill_o(perf_kill_o)
    );

    pipe_if_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_wrap (
        .clk(clk), .rst(rst), .stall_i(w_stall), .redirect_i(w_redir),
        .redirect_pc_i(w_rpc), .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_gnt_i(w_gnt), .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
        .if_valid_o(w_valid), .if_pc_o(w_pc), .if_inst_o(w_inst), .if_npc_o(w_npc),
        .perf_fetch_o(w_pf), .perf_kill_o(w_pk)
    );

    int checks = 0;
    int errors = 0;
    int lat    = 1;

    // Model state
    logic [31:0] pc_m;
    logic [31:0] live_q[$];   // fetched, not killed, not yet consumed, program order
    bit          outs_q[$];   // granted requests awaiting rvalid, flag = will be dropped
    int unsigned exp_fetch, exp_kill;
    bit          prev_hold, prev_redir;
    logic [31:0] prev_pc, prev_inst, prev_npc;
    logic [31:0] hs_log[$], del_pc[$], del_npc[$], del_inst[$];
    logic [31:0] wrap_hs[$];
    bit          wrap_seen = 1'b0;
    logic [31:0] wrap_pc, wrap_npc, wrap_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory for the main DUT: one response per grant, lat cycles after the grant cycle.
    initial begin : mem
        logic        hs, pend;
        logic [31:0] ha, p_addr;
        int          p_cnt;
        pend = 1'b0; p_addr = '0; p_cnt = 0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            hs = imem_req_o && imem_gnt_i && !rst;
            ha = imem_addr_o;
            tick();
            imem_rvalid_i = 1'b0;
            if (hs) begin
                pend   = 1'b1;
                p_addr = ha;
                p_cnt  = lat;
            end
            if (pend) begin
                p_cnt--;
                if (p_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = inst_of(p_addr);
                    pend          = 1'b0;
                end
            end
        end
    end

    // Always-granting 1-cycle memory for the wrap-around instance.
    initial begin : wrap_mem
        logic        hs_w;
        logic [31:0] a_w;
        w_stall = 1'b0; w_redir = 1'b0; w_rpc = '0;
        w_gnt = 1'b1; w_rvalid = 1'b0; w_rdata = '0;
        forever begin
            @(negedge clk);
            hs_w = w_req && w_gnt && !rst;
            a_w  = w_addr;
            if (hs_w && wrap_hs.size() < 2) wrap_hs.push_back(a_w);
            if (!rst && w_valid && !wrap_seen) begin
                wrap_seen = 1'b1;
                wrap_pc   = w_pc;
                wrap_npc  = w_npc;
                wrap_inst = w_inst;
            end
            tick();
            w_rvalid = hs_w;
            w_rdata  = inst_of(a_w);
        end
    end

    initial begin : compare
        bit hs, consumed, dropped;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_valid", 32'(if_valid_o), 32'h0);
                chk("rst_pc", if_pc_o, 32'h0);
                chk("rst_inst", if_inst_o, 32'h0);
                chk("rst_npc", if_npc_o, 32'h0);
                chk("rst_req", 32'(imem_req_o), 32'h1);
                chk("rst_addr", imem_addr_o, RstPc);
                chk("rst_perf_fetch", perf_fetch_o, 32'h0);
                chk("rst_perf_kill", perf_kill_o, 32'h0);
                chk("rst_wrap_perf", w_pf | w_pk, 32'h0);
                pc_m = RstPc;
                live_q.delete();
                outs_q.delete();
                exp_fetch  = 0;
                exp_kill   = 0;
                prev_hold  = 1'b0;
                prev_redir = 1'b0;
            end else begin
                if (imem_req_o) chk("req_addr", imem_addr_o, pc_m);
                if (prev_redir) chk("valid_after_redirect", 32'(if_valid_o), 32'h0);
                if (prev_hold) begin
                    chk("stall_hold_valid", 32'(if_valid_o), 32'h1);
                    chk("stall_hold_pc", if_pc_o, prev_pc);
                    chk("stall_hold_inst", if_inst_o, prev_inst);
                    chk("stall_hold_npc", if_npc_o, prev_npc);
                end
                if (if_valid_o) begin
                    chk("slot_npc", if_npc_o, if_pc_o + 32'd4);
                    chk("slot_inst", if_inst_o, inst_of(if_pc_o));
                end
                chk("perf_fetch", perf_fetch_o, PerfEn ? 32'(exp_fetch) : 32'h0);
                chk("perf_kill", perf_kill_o, PerfEn ? 32'(exp_kill) : 32'h0);

                consumed = if_valid_o && !stall_i && !redirect_i;
                if (consumed) begin
                    if (live_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL delivery_order actual=0x%08h required=no delivery", if_pc_o);
                    end else begin
                        chk("delivery_order", if_pc_o, live_q.pop_front());
                    end
                    exp_fetch++;
                    del_pc.push_back(if_pc_o);
                    del_npc.push_back(if_npc_o);
                    del_inst.push_back(if_inst_o);
                end

                hs = imem_req_o && imem_gnt_i;
                if (imem_rvalid_i && outs_q.size() > 0) begin
                    dropped = outs_q.pop_front() || redirect_i;
                    if (dropped) exp_kill++;
                end
                if (redirect_i) begin
                    live_q.delete();
                    foreach (outs_q[i]) outs_q[i] = 1'b1;
                    if (hs) outs_q.push_back(1'b1);
                    pc_m = redirect_pc_i & 32'hFFFF_FFFC;
                end else if (hs) begin
                    live_q.push_back(imem_addr_o);
                    outs_q.push_back(1'b0);
                    pc_m = pc_m + 32'd4;
                end
                if (hs) hs_log.push_back(imem_addr_o);

                prev_redir = redirect_i;
                prev_hold  = if_valid_o && stall_i && !redirect_i;
                prev_pc    = if_pc_o;
                prev_inst  = if_inst_o;
                prev_npc   = if_npc_o;
            end
        end
    end

    task automatic do_reset(input int l);
        rst = 1'b1; imem_gnt_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; lat = l;
        repeat (4) tick();
        rst = 1'b0;
        imem_gnt_i = 1'b1;
    endtask

    // Waits for a request (optionally granted) to address a; returns just after that cycle's edge.
    task automatic wait_fetch(input string name, input logic [31:0] a, input bit need_gnt,
                              input int maxc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < maxc && !found; i++) begin
            @(negedge clk);
            if (imem_req_o && (imem_gnt_i || !need_gnt) && imem_addr_o == a) found = 1'b1;
            tick();
        end
        chk(name, 32'(found), 32'h1);
    endtask

    initial begin : stim
        int b;
        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;

        // 1: straight-line fetch, 1-cycle memory
        do_reset(1);
        repeat (8) tick();
        chk("t1_hs0", qget(hs_log, 0), 32'h0);
        chk("t1_hs1", qget(hs_log, 1), 32'h4);
        chk("t1_hs2", qget(hs_log, 2), 32'h8);
        chk("t1_pc0", qget(del_pc, 0), 32'h0);
        chk("t1_pc1", qget(del_pc, 1), 32'h4);
        chk("t1_pc2", qget(del_pc, 2), 32'h8);
        chk("t1_npc0", qget(del_npc, 0), 32'h4);
        chk("t1_npc2", qget(del_npc, 2), 32'hC);

        // 5: wrap-around instance ran alongside test 1
        chk("t5_hs0", qget(wrap_hs, 0), 32'hFFFF_FFFC);
        chk("t5_hs1", qget(wrap_hs, 1), 32'h0);
        chk("t5_seen", 32'(wrap_seen), 32'h1);
        chk("t5_pc", wrap_pc, 32'hFFFF_FFFC);
        chk("t5_npc", wrap_npc, 32'h0);
        chk("t5_inst", wrap_inst, inst_of(32'hFFFF_FFFC));

        // 2: stall while slot holds 0x8 and 0xC arrives
        do_reset(1);
        wait_fetch("t2_hs8", 32'h8, 1'b1, 20);
        tick();
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) chk("t2_no_req_hold", 32'(imem_req_o), 32'h0);
            chk("t2_stall_pc", if_pc_o, 32'h8);
            tick();
        end
        stall_i = 1'b0;
        tick();
        @(negedge clk);
        chk("t2_valid", 32'(if_valid_o), 32'h1);
        chk("t2_pc", if_pc_o, 32'hC);
        chk("t2_req", 32'(imem_req_o), 32'h1);
        chk("t2_addr", imem_addr_o, 32'h10);

        // 3: redirect while the 0x10 response is pending (3-cycle memory)
        do_reset(3);
        wait_fetch("t3_hs10", 32'h10, 1'b1, 60);
        redirect_i = 1'b1; redirect_pc_i = 32'h103;
        tick();
        redirect_i = 1'b0;
        b = del_pc.size();
        @(negedge clk);
        chk("t3_valid_a", 32'(if_valid_o), 32'h0);
        chk("t3_req_a", 32'(imem_req_o), 32'h0);
        tick();
        @(negedge clk);
        chk("t3_valid_b", 32'(if_valid_o), 32'h0);
        tick();
        @(negedge clk);
        chk("t3_req", 32'(imem_req_o), 32'h1);
        chk("t3_addr", imem_addr_o, 32'h100);
        chk("t3_perf_kill", perf_kill_o, PerfEn ? 32'd1 : 32'd0);
        repeat (12) tick();
        chk("t3_first_after", qget(del_pc, b), 32'h100);

        // 4: redirect in the same cycle as the grant for 0x20
        do_reset(1);
        wait_fetch("t4_hs1c", 32'h1C, 1'b1, 40);
        imem_gnt_i = 1'b0;
        wait_fetch("t4_req20", 32'h20, 1'b0, 10);
        b = del_pc.size();
        imem_gnt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("t4_valid", 32'(if_valid_o), 32'h0);
        chk("t4_no_req", 32'(imem_req_o), 32'h0);
        tick();
        @(negedge clk);
        chk("t4_req", 32'(imem_req_o), 32'h1);
        chk("t4_addr", imem_addr_o, 32'h40);
        chk("t4_perf_kill", perf_kill_o, PerfEn ? 32'd1 : 32'd0);
        repeat (8) tick();
        chk("t4_first_after", qget(del_pc, b), 32'h40);
        chk("t4_second_after", qget(del_pc, b + 1), 32'h44);

        // 6: reset while waiting; stale response arrives after release
        do_reset(3);
        wait_fetch("t6_hs4", 32'h4, 1'b1, 30);
        rst = 1'b1; imem_gnt_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_stale_valid", 32'(if_valid_o), 32'h0);
        chk("t6_req", 32'(imem_req_o), 32'h1);
        chk("t6_addr", imem_addr_o, RstPc);
        tick();
        imem_gnt_i = 1'b1;
        b = del_pc.size();
        repeat (12) tick();
        chk("t6_first_pc", qget(del_pc, b), RstPc);
        chk("t6_first_inst", qget(del_inst, b), inst_of(RstPc));
        chk("t6_perf_kill", perf_kill_o, 32'h0);

        // 7: mixed stall/grant pattern with two redirects, 2-cycle memory
        do_reset(2);
        begin
            logic [15:0] stall_pat, gnt_pat;
            stall_pat = 16'b0110_0011_1000_1101;
            gnt_pat   = 16'b1111_0111_1101_1111;
            for (int i = 0; i < 48; i++) begin
                stall_i       = stall_pat[i % 16];
                imem_gnt_i    = gnt_pat[(i * 3) % 16];
                redirect_i    = (i == 20) || (i == 37);
                redirect_pc_i = (i == 20) ? 32'h203 : 32'h1FF;
                tick();
            end
        end
        stall_i = 1'b0; imem_gnt_i = 1'b1; redirect_i = 1'b0;
        repeat (15) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
